// File: rtl/data_mem_port.sv
// Memory-stage load/store port: turns one MemRead/MemWrite per instruction into a
// single req/ack word-bus transaction with byte lanes, stalling the pipeline until it completes.
module data_mem_port #(
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       RdData,
  output logic              Stall,
  output logic              AccessErr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             op_load;
  logic [2:0]       op_f3;
  logic [1:0]       op_k;

  logic        req;
  logic        is_store;
  logic        legal;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;

  // Address bits above the bus word address are not decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:ADDR_W+2];

  // Shift the addressed lane(s) down to bit 0 and extend per the load kind.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  k,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {k, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_BU:   return {24'b0, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_HU:   return {16'b0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips one infers a latch.
    req       = MemRead | MemWrite;
    is_store  = MemWrite;
    legal     = 1'b0;
    be_nxt    = 4'b0000;
    wdata_nxt = '0;
    case (Funct3)
      F3_B, F3_BU: begin
        legal     = !(is_store && Funct3 == F3_BU);
        be_nxt    = 4'b0001 << Addr[1:0];
        wdata_nxt = {4{WrData[7:0]}};
      end
      F3_H, F3_HU: begin
        legal     = !Addr[0] && !(is_store && Funct3 == F3_HU);
        be_nxt    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{WrData[15:0]}};
      end
      F3_W: begin
        legal     = (Addr[1:0] == 2'b00);
        be_nxt    = 4'b1111;
        wdata_nxt = WrData;
      end
      default: legal = 1'b0;
    endcase
    if (!is_store) wdata_nxt = '0;
  end

  // The stall must cover the request cycle itself, so IDLE contributes combinationally.
  assign Stall = (state == S_WAIT) || (state == S_IDLE && req && legal);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      RdData    <= '0;
      AccessErr <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= '0;
      op_load   <= 1'b0;
      op_f3     <= 3'b000;
      op_k      <= 2'b00;
    end else begin
      AccessErr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (legal) begin
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_be    <= be_nxt;
              bus_addr  <= Addr[ADDR_W+1:2];
              bus_wdata <= wdata_nxt;
              op_load   <= !is_store;
              op_f3     <= Funct3;
              op_k      <= Addr[1:0];
              wait_cnt  <= '0;
              state     <= S_WAIT;
            end else begin
              AccessErr <= 1'b1;
              RdData    <= '0;
            end
          end
        end
        S_WAIT: begin
          // An ack arriving in the last allowed cycle beats the timeout.
          if (bus_ack) begin
            bus_req  <= 1'b0;
            if (op_load) RdData <= extend_load(op_f3, op_k, bus_rdata);
            wait_cnt <= '0;
            state    <= S_DONE;
          end else if (wait_cnt == LAST_CNT) begin
            bus_req   <= 1'b0;
            RdData    <= '0;
            AccessErr <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        // The request still visible here belongs to the finished instruction.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: directed vector table, reset/back-to-back
// sequences and randomized accesses checked against a spec-level reference model.
module tb_data_mem_port;

  localparam int ADDR_W = 9;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              MemRead, MemWrite;
  logic [2:0]        Funct3;
  logic [31:0]       Addr, WrData;
  logic [31:0]       RdData;
  logic              Stall, AccessErr;
  logic              bus_req, bus_we;
  logic [3:0]        bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata, bus_rdata;
  logic              bus_ack;

  data_mem_port #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
    .Stall(Stall), .AccessErr(AccessErr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;
  logic req_q  = 1'b0;
  logic [31:0] model_rd;

  // Counts bus transactions as rising edges of bus_req.
  always @(posedge clk) begin
    req_q <= bus_req;
    if (bus_req && !req_q) n_txn <= n_txn + 1;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  typedef struct {
    logic              legal;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] baddr;
    logic [31:0]       ld;
  } exp_t;

  // Reference model: derived from access size, byte offset and arithmetic on the words.
  function automatic exp_t model(input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd);
    exp_t e;
    int size, k;
    logic [31:0] v;
    k    = int'(a % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.legal = (st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
              && (a % size == 0);
    e.baddr = ADDR_W'(a / 4);
    if (size == 1)      e.be = 4'(1 << k);
    else if (size == 2) e.be = (k >= 2) ? 4'hC : 4'h3;
    else                e.be = 4'hF;
    if (!st)            e.wdata = 32'h0;
    else if (size == 1) e.wdata = {24'h0, wd[7:0]} * 32'h01010101;
    else if (size == 2) e.wdata = {16'h0, wd[15:0]} * 32'h00010001;
    else                e.wdata = wd;
    v = rd >> (8 * k);
    if (size == 1) begin
      v = v % 256;
      if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
    end else if (size == 2) begin
      v = v % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
    end
    e.ld = v;
    return e;
  endfunction

  // Called at posedge+1 in an IDLE cycle. ack_at = WAIT cycle carrying bus_ack; 0 or >TO = never.
  task automatic run_access(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input int ack_at, input logic drop,
                            output int stall_cnt, output logic err, output logic [31:0] rdo,
                            output logic [3:0] be, output logic [ADDR_W-1:0] baddr,
                            output logic [31:0] wdata);
    exp_t e;
    int   nwait;
    logic tmo;
    e = model(st, f3, a, wd, rd);
    stall_cnt = 0; be = '0; baddr = '0; wdata = '0;
    MemWrite = st; MemRead = !st; Funct3 = f3; Addr = a; WrData = wd; bus_ack = 1'b0;
    #1;
    check({tag, " stall_req"}, Stall, e.legal);
    if (Stall) stall_cnt++;
    if (!e.legal) begin
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      model_rd = 32'h0;
      check({tag, " err"}, AccessErr, 1'b1);
      check({tag, " no_bus_req"}, bus_req, 1'b0);
      check({tag, " rd"}, RdData, model_rd);
      check({tag, " stall_err"}, Stall, 1'b0);
      err = AccessErr; rdo = RdData;
      return;
    end
    tmo   = !(ack_at >= 1 && ack_at <= TO);
    nwait = tmo ? TO : ack_at;
    for (int w = 1; w <= nwait; w++) begin
      @(posedge clk); #1;
      check({tag, " bus_req"}, bus_req, 1'b1);
      check({tag, " stall_wait"}, Stall, 1'b1);
      check({tag, " err_wait"}, AccessErr, 1'b0);
      check({tag, " we"}, bus_we, st);
      check({tag, " be"}, bus_be, e.be);
      check({tag, " addr"}, bus_addr, e.baddr);
      check({tag, " wdata"}, bus_wdata, e.wdata);
      check({tag, " rd_hold"}, RdData, model_rd);
      if (Stall) stall_cnt++;
      if (w == 1) begin be = bus_be; baddr = bus_addr; wdata = bus_wdata; end
      bus_ack   = (w == nwait) && !tmo;
      bus_rdata = bus_ack ? rd : $urandom;
    end
    @(posedge clk); #1;
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (tmo) model_rd = 32'h0;
    else if (!st) model_rd = e.ld;
    check({tag, " stall_done"}, Stall, 1'b0);
    check({tag, " bus_req_done"}, bus_req, 1'b0);
    check({tag, " err_done"}, AccessErr, tmo);
    check({tag, " rd_done"}, RdData, model_rd);
    if (Stall) stall_cnt++;
    err = AccessErr; rdo = RdData;
    @(posedge clk); #1;
    if (drop) begin MemRead = 1'b0; MemWrite = 1'b0; end
    check({tag, " err_clear"}, AccessErr, 1'b0);
    check({tag, " idle_req"}, bus_req, 1'b0);
  endtask

  typedef struct {
    logic              st;
    logic [2:0]        f3;
    logic [31:0]       a, wd, rd;
    int                ack_at;
    int                exp_stall;
    logic              exp_err;
    logic [31:0]       exp_rd;
    logic [3:0]        exp_be;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_wdata;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          sc;
    logic        er;
    logic [31:0] ro, wo;
    logic [3:0]  bo;
    logic [ADDR_W-1:0] ao;
    int          txn0;

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
    Addr = 32'h0; WrData = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    model_rd = 32'h0;

    vecs[0]  = '{1'b1, 3'd2, 32'h10,       32'hDEADBEEF, 32'h0,        2, 3, 1'b0, 32'h00000000, 4'hF, 9'h004, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'd0, 32'h13,       32'h0,        32'h80FFFF7F, 1, 2, 1'b0, 32'hFFFFFF80, 4'h8, 9'h004, 32'h0};
    vecs[2]  = '{1'b0, 3'd4, 32'h13,       32'h0,        32'h80FFFF7F, 1, 2, 1'b0, 32'h00000080, 4'h8, 9'h004, 32'h0};
    vecs[3]  = '{1'b1, 3'd1, 32'h06,       32'h0000ABCD, 32'h0,        3, 4, 1'b0, 32'h00000080, 4'hC, 9'h001, 32'hABCDABCD};
    vecs[4]  = '{1'b0, 3'd1, 32'h05,       32'h0,        32'h0,        1, 0, 1'b1, 32'h00000000, 4'h0, 9'h000, 32'h0};
    vecs[5]  = '{1'b0, 3'd2, 32'h20,       32'h0,        32'h55555555, 0, 5, 1'b1, 32'h00000000, 4'hF, 9'h008, 32'h0};
    vecs[6]  = '{1'b0, 3'd2, 32'h24,       32'h0,        32'h12345678, 4, 5, 1'b0, 32'h12345678, 4'hF, 9'h009, 32'h0};
    vecs[7]  = '{1'b0, 3'd5, 32'h2A,       32'h0,        32'hBEEF1234, 1, 2, 1'b0, 32'h0000BEEF, 4'hC, 9'h00A, 32'h0};
    vecs[8]  = '{1'b0, 3'd1, 32'h2A,       32'h0,        32'hBEEF1234, 1, 2, 1'b0, 32'hFFFFBEEF, 4'hC, 9'h00A, 32'h0};
    vecs[9]  = '{1'b1, 3'd0, 32'h31,       32'h000000A5, 32'h0,        2, 3, 1'b0, 32'hFFFFBEEF, 4'h2, 9'h00C, 32'hA5A5A5A5};
    vecs[10] = '{1'b0, 3'd3, 32'h40,       32'h0,        32'h0,        1, 0, 1'b1, 32'h00000000, 4'h0, 9'h000, 32'h0};
    vecs[11] = '{1'b1, 3'd4, 32'h40,       32'h0,        32'h0,        1, 0, 1'b1, 32'h00000000, 4'h0, 9'h000, 32'h0};
    vecs[12] = '{1'b0, 3'd2, 32'h42,       32'h0,        32'h0,        1, 0, 1'b1, 32'h00000000, 4'h0, 9'h000, 32'h0};
    vecs[13] = '{1'b1, 3'd2, 32'hFFFFF7FC, 32'h11223344, 32'h0,        1, 2, 1'b0, 32'h00000000, 4'hF, 9'h1FF, 32'h11223344};

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    check("reset rd", RdData, 32'h0);
    check("reset err", AccessErr, 1'b0);
    check("reset req", bus_req, 1'b0);
    check("reset we", bus_we, 1'b0);
    check("reset be", bus_be, 4'h0);
    check("reset addr", bus_addr, 9'h0);
    check("reset wdata", bus_wdata, 32'h0);
    check("reset stall", Stall, 1'b0);
    reset = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      run_access($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd,
                 vecs[i].rd, vecs[i].ack_at, 1'b1, sc, er, ro, bo, ao, wo);
      check($sformatf("vec%0d stall_cycles", i), sc, vecs[i].exp_stall);
      check($sformatf("vec%0d err_out", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d rd_out", i), ro, vecs[i].exp_rd);
      if (vecs[i].exp_stall > 0) begin
        check($sformatf("vec%0d be_out", i), bo, vecs[i].exp_be);
        check($sformatf("vec%0d addr_out", i), ao, vecs[i].exp_addr);
        check($sformatf("vec%0d wdata_out", i), wo, vecs[i].exp_wdata);
      end
    end

    // Reset during WAIT aborts the access; a late ack is ignored.
    txn0 = n_txn;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; Addr = 32'h80; bus_ack = 1'b0;
    @(posedge clk); #1;
    check("rst_wait req", bus_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    check("rst_wait req_drop", bus_req, 1'b0);
    check("rst_wait stall", Stall, 1'b0);
    check("rst_wait rd", RdData, 32'h0);
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("late_ack req", bus_req, 1'b0);
    check("late_ack stall", Stall, 1'b0);
    check("late_ack rd", RdData, 32'h0);
    check("late_ack err", AccessErr, 1'b0);
    check("rst_wait txn", n_txn - txn0, 1);
    model_rd = 32'h0;

    // Two LW with MemRead held across DONE: exactly two transactions.
    txn0 = n_txn;
    run_access("b2b0", 1'b0, 3'd2, 32'h100, 32'h0, 32'hA1A2A3A4, 1, 1'b0, sc, er, ro, bo, ao, wo);
    check("b2b0 rd_out", ro, 32'hA1A2A3A4);
    run_access("b2b1", 1'b0, 3'd2, 32'h100, 32'h0, 32'hB1B2B3B4, 2, 1'b1, sc, er, ro, bo, ao, wo);
    check("b2b1 rd_out", ro, 32'hB1B2B3B4);
    @(posedge clk); #1;
    check("b2b txn_count", n_txn - txn0, 2);

    // Randomized accesses against the model.
    for (int r = 0; r < 60; r++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      run_access($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ra, $urandom, $urandom, $urandom_range(0, 5), 1'b1, sc, er, ro, bo, ao, wo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
